// File: rtl/mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_unit
// Brief    : CPU store path. Stores are lane-formatted at acceptance into a
//            2-entry FIFO, then issued to memory one at a time. A request
//            that is not acknowledged in time is dropped with a bus error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        align_err,
  output logic        bus_err,
  output logic        idle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  // The wait counter only needs to reach TIMEOUT-1.
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0]        SZ_BYTE   = 2'b00;
  localparam logic [1:0]        SZ_HALF   = 2'b01;
  localparam logic [1:0]        FIFO_FULL = 2'd2;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [1:0]          count_q, count_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                align_err_q, align_err_d;

  logic [31:0]         addr_q  [2];
  logic [31:0]         wdata_q [2];
  logic [3:0]          be_q    [2];

  logic                w_push;
  logic                w_pop;
  logic                w_head_valid;
  logic [31:0]         w_lane_wdata;
  logic [3:0]          w_lane_be;
  logic                w_misalign;

  // Ready is forced low while reset is asserted so nothing slips in.
  assign st_ready     = (count_q < FIFO_FULL) && rst_n;
  assign w_push       = st_valid && st_ready;
  // ERR always discards the head; ISSUE retires it on an acknowledge.
  assign w_pop        = (((state_q == S_ISSUE) && mem_ack) || (state_q == S_ERR))
                        && (count_q != 2'd0);
  assign w_head_valid = (count_q != 2'd0);

  // Lane formation and misalignment detection for the incoming store.
  always_comb begin
    w_lane_wdata = st_data;
    w_lane_be    = 4'b1111;
    w_misalign   = (st_addr[1:0] != 2'b00);
    case (st_size)
      SZ_BYTE: begin
        w_lane_wdata = {4{st_data[7:0]}};
        w_lane_be    = 4'b0001 << st_addr[1:0];
        w_misalign   = 1'b0;
      end
      SZ_HALF: begin
        w_lane_wdata = {2{st_data[15:0]}};
        w_lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_misalign   = st_addr[0];
      end
      default: begin
        // Word and the reserved encoding both behave as a full word.
        w_lane_wdata = st_data;
        w_lane_be    = 4'b1111;
        w_misalign   = (st_addr[1:0] != 2'b00);
      end
    endcase
  end

  // FIFO payload storage; entries are written already lane-formatted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else if (w_push) begin
      addr_q[wr_ptr_q]  <= {st_addr[31:2], 2'b00};
      wdata_q[wr_ptr_q] <= w_lane_wdata;
      be_q[wr_ptr_q]    <= w_lane_be;
    end
  end

  // FIFO pointer/occupancy next-state and the misalignment pulse.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    align_err_d = w_push && w_misalign;
    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      align_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      align_err_q <= align_err_d;
    end
  end

  // Issue FSM: next state, wait counter and request/error outputs.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    mem_req = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (count_q != 2'd0) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          // An ack on the last allowed cycle still completes normally.
          wait_d = '0;
          if (count_d == 2'd0) begin
            state_d = S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_ERR: begin
        bus_err = 1'b1;
        wait_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        wait_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The head entry is presented only when the FIFO holds something.
  assign mem_addr  = w_head_valid ? addr_q[rd_ptr_q]  : 32'd0;
  assign mem_wdata = w_head_valid ? wdata_q[rd_ptr_q] : 32'd0;
  assign mem_be    = w_head_valid ? be_q[rd_ptr_q]    : 4'd0;
  assign align_err = align_err_q;
  assign idle      = (count_q == 2'd0) && (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_store_unit
// Brief    : Self-checking bench for mem_store_unit: directed scenarios plus
//            a randomized store/ack stream checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_store_unit;

  localparam int TB_TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        align_err;
  logic        bus_err;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;

  mem_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .align_err (align_err),
    .bus_err   (bus_err),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Reference: a store of nb bytes occupies lanes [off, off+nb) of the word,
  // with off rounded down to the access size; each lane repeats source byte
  // (lane mod nb).
  function automatic exp_t ref_store(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz);
    exp_t        e;
    int          nb;
    int          off;
    logic [31:0] w;
    logic [3:0]  be;
    nb    = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    off   = int'(a[1:0]);
    e.mis = (off % nb) != 0;
    off   = off - (off % nb);
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = d[8*(b % nb) +: 8];
      be[b]       = (b >= off) && (b < off + nb);
    end
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = w;
    e.be    = be;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    st_valid = 1'b1;
    st_addr  = $urandom;
    st_data  = $urandom;
    st_size  = 2'b11;
    mem_ack  = 1'b1;
    tick();
    n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL reset_st_ready: got %b want 0", st_ready); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_tests++; if ({align_err, bus_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err_flags: got %b want 00", {align_err, bus_err}); end
    n_tests++; if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin n_fail++; $display("FAIL reset_head: got %h want 0", {mem_addr, mem_wdata, mem_be}); end
    tick();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    rst_n    = 1'b1;
    #1;
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", st_ready); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_release_idle: got %b want 1", idle); end
  endtask

  // One store into an idle unit, acknowledged on the delay-th request cycle.
  task automatic run_single(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input exp_t e, input int delay, input string tag);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    tick();
    st_valid = 1'b0;
    st_addr  = $urandom;
    st_data  = $urandom;
    st_size  = 2'($urandom_range(0, 3));
    n_tests++; if (align_err !== e.mis) begin n_fail++; $display("FAIL %s_align: got %b want %b", tag, align_err, e.mis); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req_latency: got %b want 0", tag, mem_req); end
    tick();
    n_tests++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL %s_align_pulse: got %b want 0", tag, align_err); end
    for (int c = 1; c <= delay; c++) begin
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s_req_high c%0d: got %b want 1", tag, c, mem_req); end
      n_tests++; if ({mem_addr, mem_wdata, mem_be} !== {e.addr, e.wdata, e.be}) begin
        n_fail++; $display("FAIL %s_head c%0d: got %h/%h/%b want %h/%h/%b", tag, c, mem_addr, mem_wdata, mem_be, e.addr, e.wdata, e.be);
      end
      n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL %s_no_bus_err c%0d: got %b want 0", tag, c, bus_err); end
      if (c == delay) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req_drop: got %b want 0", tag, mem_req); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL %s_done_bus_err: got %b want 0", tag, bus_err); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL %s_idle: got %b want 1", tag, idle); end
    n_tests++; if (mem_be !== 4'd0) begin n_fail++; $display("FAIL %s_empty_be: got %b want 0000", tag, mem_be); end
  endtask

  task automatic test_byte_directed();
    exp_t e;
    e.addr = 32'h0000_1000; e.wdata = 32'hABAB_ABAB; e.be = 4'b1000; e.mis = 1'b0;
    run_single(32'h0000_1003, 32'h0000_00AB, 2'b00, e, 3, "byte_1003");
  endtask

  task automatic test_half_misaligned();
    exp_t e;
    e.addr = 32'h0000_2000; e.wdata = 32'h1234_1234; e.be = 4'b0011; e.mis = 1'b1;
    run_single(32'h0000_2001, 32'h0000_1234, 2'b01, e, 2, "half_2001");
  endtask

  task automatic test_lanes();
    logic [31:0] a, d;
    logic [1:0]  sz;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      run_single(a, d, sz, ref_store(a, d, sz), $urandom_range(1, 4), "lanes");
    end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (idle !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got idle=%b req=%b want idle=1 req=0", idle, mem_req); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3];
    logic [31:0] d[3];
    exp_t        w[3];
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom & 32'hFFFF_FFFC;
      d[i] = $urandom;
      w[i] = ref_store(a[i], d[i], 2'b11);
    end
    st_valid = 1'b1; st_addr = a[0]; st_data = d[0]; st_size = 2'b11;
    tick();
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b want 1", st_ready); end
    st_addr = a[1]; st_data = d[1];
    tick();
    n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %b want 0", st_ready); end
    st_addr = a[2]; st_data = d[2];
    tick();
    n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_still_full: got %b want 0", st_ready); end
    n_tests++; if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_be} !== {w[0].addr, w[0].wdata, w[0].be}) begin
      n_fail++; $display("FAIL b2b_first: got req=%b %h/%h want req=1 %h/%h", mem_req, mem_addr, mem_wdata, w[0].addr, w[0].wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_be} !== {w[1].addr, w[1].wdata, w[1].be}) begin
      n_fail++; $display("FAIL b2b_second: got req=%b %h/%h want req=1 %h/%h", mem_req, mem_addr, mem_wdata, w[1].addr, w[1].wdata);
    end
    n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_ack: got %b want 1", st_ready); end
    tick();
    st_valid = 1'b0;
    n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_taken: got %b want 0", st_ready); end
    n_tests++; if ({mem_addr, mem_wdata} !== {w[1].addr, w[1].wdata}) begin
      n_fail++; $display("FAIL b2b_second_stable: got %h/%h want %h/%h", mem_addr, mem_wdata, w[1].addr, w[1].wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_be} !== {w[2].addr, w[2].wdata, w[2].be}) begin
      n_fail++; $display("FAIL b2b_third: got req=%b %h/%h want req=1 %h/%h", mem_req, mem_addr, mem_wdata, w[2].addr, w[2].wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", idle); end
  endtask

  task automatic test_timeout();
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  s0, s1;
    exp_t        ea, eb;
    int          req_cycles;
    a0 = $urandom; d0 = $urandom; s0 = 2'($urandom_range(0, 3)); ea = ref_store(a0, d0, s0);
    a1 = $urandom; d1 = $urandom; s1 = 2'($urandom_range(0, 3)); eb = ref_store(a1, d1, s1);
    st_valid = 1'b1; st_addr = a0; st_data = d0; st_size = s0;
    tick();
    st_addr = a1; st_data = d1; st_size = s1;
    tick();
    st_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      req_cycles++;
      tick();
    end
    n_tests++; if (req_cycles != TB_TIMEOUT) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want %0d", req_cycles, TB_TIMEOUT); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_bus_err: got %b want 1", bus_err); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_err_req: got %b want 0", mem_req); end
    tick();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_bus_err_pulse: got %b want 0", bus_err); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL timeout_second_pending: got idle=%b want 0", idle); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_be} !== {eb.addr, eb.wdata, eb.be}) begin
      n_fail++; $display("FAIL timeout_next_issued: got req=%b %h/%h/%b want req=1 %h/%h/%b", mem_req, mem_addr, mem_wdata, mem_be, eb.addr, eb.wdata, eb.be);
    end
    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      n_tests++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_wait c%0d: got req=%b err=%b want req=1 err=0", c, mem_req, bus_err); end
      if (c == TB_TIMEOUT) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_bus_err: got %b want 0", bus_err); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL late_ack_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_in_issue();
    st_valid = 1'b1; st_addr = $urandom; st_data = $urandom; st_size = 2'b11;
    tick();
    st_addr = $urandom; st_data = $urandom;
    tick();
    st_valid = 1'b0;
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_issue_setup: got %b want 1", mem_req); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_issue_req: got %b want 0", mem_req); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_issue_idle: got %b want 1", idle); end
    n_tests++; if (mem_be !== 4'd0) begin n_fail++; $display("FAIL rst_issue_flushed: got %b want 0000", mem_be); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (idle !== 1'b1 || mem_req !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_ack: got idle=%b req=%b err=%b want 1/0/0", idle, mem_req, bus_err);
    end
    tick();
    n_tests++; if (idle !== 1'b1 || st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_after: got idle=%b ready=%b want 1/1", idle, st_ready); end
  endtask

  // Random stores and acks; the model is the ordered list of pending stores.
  task automatic test_random_stream();
    exp_t q[$];
    exp_t e;
    bit   exp_align;
    bit   acc;
    bit   done;
    int   stall;
    int   low_run;
    exp_align = 1'b0;
    stall     = 0;
    low_run   = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      n_tests++; if (idle !== (q.size() == 0)) begin n_fail++; $display("FAIL stream_idle cyc%0d: got %b want %b", cyc, idle, q.size() == 0); end
      n_tests++; if (st_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL stream_ready cyc%0d: got %b want %b", cyc, st_ready, q.size() < 2); end
      n_tests++; if (align_err !== exp_align) begin n_fail++; $display("FAIL stream_align cyc%0d: got %b want %b", cyc, align_err, exp_align); end
      if (q.size() == 0) begin
        n_tests++; if ({mem_req, mem_addr, mem_wdata, mem_be} !== 69'd0) begin
          n_fail++; $display("FAIL stream_empty cyc%0d: got req=%b %h/%h/%b want all 0", cyc, mem_req, mem_addr, mem_wdata, mem_be);
        end
      end else begin
        n_tests++; if ({mem_addr, mem_wdata, mem_be} !== {q[0].addr, q[0].wdata, q[0].be}) begin
          n_fail++; $display("FAIL stream_head cyc%0d: got %h/%h/%b want %h/%h/%b", cyc, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].wdata, q[0].be);
        end
        low_run = (mem_req !== 1'b1) ? low_run + 1 : 0;
        n_tests++; if (low_run > 1) begin n_fail++; $display("FAIL stream_progress cyc%0d: got %0d idle cycles want <=1", cyc, low_run); end
      end
      if (q.size() == 0) low_run = 0;
      st_valid = (cyc < 380) && ($urandom_range(0, 1) == 1);
      st_addr  = $urandom;
      st_data  = $urandom;
      st_size  = 2'($urandom_range(0, 3));
      if (mem_req === 1'b1) mem_ack = (stall >= 8) || ($urandom_range(0, 2) == 0);
      else                  mem_ack = ($urandom_range(0, 5) == 0);
      acc   = st_valid && (q.size() < 2);
      done  = (mem_req === 1'b1) && mem_ack;
      e     = ref_store(st_addr, st_data, st_size);
      stall = ((mem_req === 1'b1) && !mem_ack) ? stall + 1 : 0;
      tick();
      if (done) void'(q.pop_front());
      if (acc) q.push_back(e);
      exp_align = acc && e.mis;
    end
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    n_tests++; if (idle !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL stream_drain: got idle=%b pending=%0d want 1/0", idle, q.size()); end
  endtask

  initial begin
    test_reset();
    test_byte_directed();
    test_half_misaligned();
    test_lanes();
    test_stray_ack();
    test_back_to_back();
    test_timeout();
    test_reset_in_issue();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
